// File: rtl/dpsk_modulator.sv
// Differential PSK modulator: bytes go out MSB first as +/-AMPLITUDE symbols, each held SAMPLES_PER_BIT cycles.
// Optional build macro DPSK_PREAMBLE_EN prepends an 8'hAA preamble to bytes accepted from IDLE.
module dpsk_modulator #(
    parameter int AMPLITUDE       = 1000,
    parameter int SAMPLES_PER_BIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [15:0] dpsk_signal,
    output logic        bit_strobe,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    localparam logic [7:0]  CNT_LAST = 8'(SAMPLES_PER_BIT - 1);
    localparam logic [15:0] AMP_P    = 16'(AMPLITUDE);
    localparam logic [15:0] AMP_N    = 16'(-AMPLITUDE);

`ifdef DPSK_PREAMBLE_EN
    localparam logic [7:0] PREAMBLE_PAT = 8'hAA;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PREAMBLE = 2'd1, S_SEND = 2'd2} state_t;
    logic [7:0] payload_q, payload_d;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd2} state_t;
`endif

    state_t      state_q, state_d;
    logic [6:0]  rest_q, rest_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sym_q, sym_d;
    logic [15:0] sig_q, sig_d;
    logic        sym_end, last_bit, accept, emit, tx_bit;

    assign sym_end  = (cnt_q == CNT_LAST);
    assign last_bit = (idx_q == 3'd7);
    assign accept   = data_valid && data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rest_q  <= 7'd0;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            sym_q   <= 1'b1;
            sig_q   <= AMP_P;
`ifdef DPSK_PREAMBLE_EN
            payload_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            rest_q  <= rest_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            sig_q   <= sig_d;
`ifdef DPSK_PREAMBLE_EN
            payload_q <= payload_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifdef DPSK_PREAMBLE_EN
                if (accept) state_d = S_PREAMBLE;
`else
                if (accept) state_d = S_SEND;
`endif
            end
`ifdef DPSK_PREAMBLE_EN
            S_PREAMBLE: if (sym_end && last_bit) state_d = S_SEND;
`endif
            S_SEND: if (sym_end && last_bit && !accept) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_ready  = (state_q == S_IDLE) || ((state_q == S_SEND) && sym_end && last_bit);
        busy        = (state_q != S_IDLE);
        bit_strobe  = busy && (cnt_q == 8'd0);
        dpsk_signal = sig_q;
        fsm_state   = state_q;
    end

    // Symbol datapath: emit picks the next data bit; encoding is relative to the last symbol sent.
    always_comb begin
        rest_d = rest_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        emit   = 1'b0;
        tx_bit = 1'b0;
`ifdef DPSK_PREAMBLE_EN
        payload_d = payload_q;
`endif
        if (state_q == S_IDLE) begin
            cnt_d = 8'd0;
            if (accept) begin
                idx_d = 3'd0;
                emit  = 1'b1;
`ifdef DPSK_PREAMBLE_EN
                payload_d = data_in;
                rest_d    = PREAMBLE_PAT[6:0];
                tx_bit    = PREAMBLE_PAT[7];
`else
                rest_d    = data_in[6:0];
                tx_bit    = data_in[7];
`endif
            end
        end else if (!sym_end) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
            if (!last_bit) begin
                idx_d  = idx_q + 3'd1;
                rest_d = {rest_q[5:0], 1'b0};
                tx_bit = rest_q[6];
                emit   = 1'b1;
            end else
`ifdef DPSK_PREAMBLE_EN
            if (state_q == S_PREAMBLE) begin
                idx_d  = 3'd0;
                rest_d = payload_q[6:0];
                tx_bit = payload_q[7];
                emit   = 1'b1;
            end else
`endif
            if (accept) begin
                idx_d  = 3'd0;
                rest_d = data_in[6:0];
                tx_bit = data_in[7];
                emit   = 1'b1;
            end
        end
        sym_d = emit ? ~(tx_bit ^ sym_q) : sym_q;
        sig_d = sym_d ? AMP_P : AMP_N;
    end

endmodule

// File: tb/tb_dpsk_modulator.sv
// Bench for dpsk_modulator: two instances (1 and 4 samples per bit) checked cycle by cycle
// against a differential-encoding model feeding expected-output queues.
module tb_dpsk_modulator;

    localparam logic [15:0] AMP_P = 16'd1000;
    localparam logic [15:0] AMP_N = 16'hFC18;  // -1000

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in_a, data_in_b;
    logic        valid_a, valid_b;
    logic        data_ready_a, data_ready_b, bit_strobe_a, bit_strobe_b, busy_a, busy_b;
    logic [15:0] dpsk_signal_a, dpsk_signal_b;
    logic [1:0]  fsm_state_a, fsm_state_b;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    logic prev_a, prev_b;
    logic [15:0] last_a, last_b;
    logic [17:0] exp_qa[$];
    logic [17:0] exp_qb[$];

    always #5 clk = ~clk;

    dpsk_modulator #(.AMPLITUDE(1000), .SAMPLES_PER_BIT(1)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in_a), .data_valid(valid_a),
        .data_ready(data_ready_a), .dpsk_signal(dpsk_signal_a),
        .bit_strobe(bit_strobe_a), .busy(busy_a), .fsm_state(fsm_state_a)
    );

    dpsk_modulator #(.AMPLITUDE(1000), .SAMPLES_PER_BIT(4)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_in_b), .data_valid(valid_b),
        .data_ready(data_ready_b), .dpsk_signal(dpsk_signal_b),
        .bit_strobe(bit_strobe_b), .busy(busy_b), .fsm_state(fsm_state_b)
    );

    // Entry layout: {data_ready, bit_strobe, dpsk_signal}
    task automatic push_sym(input bit which, input logic d, input logic rdy_last);
        logic s;
        int spb;
        logic [17:0] e;
        if (which) begin s = ~(d ^ prev_b); prev_b = s; spb = 4; end
        else begin s = ~(d ^ prev_a); prev_a = s; spb = 1; end
        for (int k = 0; k < spb; k++) begin
            e = {rdy_last && (k == spb - 1), (k == 0), (s ? AMP_P : AMP_N)};
            if (which) exp_qb.push_back(e); else exp_qa.push_back(e);
        end
    endtask

    task automatic push_byte(input bit which, input logic [7:0] b, input bit from_idle);
`ifdef DPSK_PREAMBLE_EN
        logic [7:0] pre;
        pre = 8'hAA;
        if (from_idle)
            for (int i = 7; i >= 0; i--) push_sym(which, pre[i], 1'b0);
`else
        if (from_idle) begin end
`endif
        for (int i = 7; i >= 0; i--) push_sym(which, b[i], (i == 0));
    endtask

    task automatic send(input bit which, input logic [7:0] b, input bit hold);
        bit ok;
        bit idle;
        ok = 1'b0;
        idle = 1'b0;
        if (which) begin data_in_b = b; valid_b = 1'b1; end
        else begin data_in_a = b; valid_a = 1'b1; end
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            ok   = which ? data_ready_b : data_ready_a;
            idle = which ? !busy_b : !busy_a;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout dut=%0d byte=%h data_ready got=0 exp=1", which, b);
        end else begin
            @(posedge clk);
            #1;
            push_byte(which, b, idle);
        end
        if (!hold) begin
            if (which) valid_b = 1'b0; else valid_a = 1'b0;
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            done = (exp_qa.size() == 0) && (exp_qb.size() == 0) && !busy_a && !busy_b;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout qa=%0d qb=%0d busy_a=%b busy_b=%b exp empty/idle",
                     exp_qa.size(), exp_qb.size(), busy_a, busy_b);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [17:0] got, e;
        if (mon_en) begin
            got = {data_ready_a, bit_strobe_a, dpsk_signal_a};
            checks++;
            if (busy_a) begin
                if (exp_qa.size() == 0) begin
                    failures++;
                    $display("FAIL mon_a unexpected busy got=%h exp=idle", got);
                end else begin
                    e = exp_qa.pop_front();
                    last_a = e[15:0];
                    if (got !== e) begin
                        failures++;
                        $display("FAIL mon_a symbol got=%h exp=%h", got, e);
                    end
                end
            end else begin
                e = {1'b1, 1'b0, last_a};
                if (got !== e || exp_qa.size() != 0) begin
                    failures++;
                    $display("FAIL mon_a idle got=%h exp=%h pending=%0d", got, e, exp_qa.size());
                end
            end
            got = {data_ready_b, bit_strobe_b, dpsk_signal_b};
            checks++;
            if (busy_b) begin
                if (exp_qb.size() == 0) begin
                    failures++;
                    $display("FAIL mon_b unexpected busy got=%h exp=idle", got);
                end else begin
                    e = exp_qb.pop_front();
                    last_b = e[15:0];
                    if (got !== e) begin
                        failures++;
                        $display("FAIL mon_b symbol got=%h exp=%h", got, e);
                    end
                end
            end else begin
                e = {1'b1, 1'b0, last_b};
                if (got !== e || exp_qb.size() != 0) begin
                    failures++;
                    $display("FAIL mon_b idle got=%h exp=%h pending=%0d", got, e, exp_qb.size());
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        logic [20:0] exp_v;
        exp_v = {2'd0, 1'b0, 1'b1, 1'b0, AMP_P};
        checks++;
        if ({fsm_state_a, busy_a, data_ready_a, bit_strobe_a, dpsk_signal_a} !== exp_v) begin
            failures++;
            $display("FAIL %s_a got=%h exp=%h", tag,
                     {fsm_state_a, busy_a, data_ready_a, bit_strobe_a, dpsk_signal_a}, exp_v);
        end
        checks++;
        if ({fsm_state_b, busy_b, data_ready_b, bit_strobe_b, dpsk_signal_b} !== exp_v) begin
            failures++;
            $display("FAIL %s_b got=%h exp=%h", tag,
                     {fsm_state_b, busy_b, data_ready_b, bit_strobe_b, dpsk_signal_b}, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_qa.delete();
        exp_qb.delete();
        prev_a = 1'b1;
        prev_b = 1'b1;
        last_a = AMP_P;
        last_b = AMP_P;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        send(1'b0, 8'hB4, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        send(1'b0, 8'hB4, 1'b1);
        send(1'b0, 8'h00, 1'b1);
        send(1'b0, 8'hFF, 1'b0);
        drain();
    endtask

    task automatic test_spb4_ignore();
        send(1'b1, 8'h80, 1'b0);
        for (int i = 0; i < 20; i++) begin
            valid_b = 1'b1;
            data_in_b = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        valid_b = 1'b0;
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) send(1'b0, 8'($urandom_range(0, 255)), (i != 4));
        for (int i = 0; i < 2; i++) send(1'b1, 8'($urandom_range(0, 255)), (i != 1));
        drain();
    endtask

    task automatic test_reset_mid();
        send(1'b0, 8'h5A, 1'b0);
        repeat (3) @(posedge clk);
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_next");
        model_reset();
        rst = 1'b0;
        mon_en = 1'b1;
        send(1'b0, 8'hFF, 1'b0);
        drain();
    endtask

    initial begin
        rst = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_in_a = 8'h00;
        data_in_b = 8'h00;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_spb4_ignore();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
